// File: rtl/button_debounce4.sv
// ---------------------------------------------------------------------------
// button_debounce4 : four-channel push-button synchronizer and debouncer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_debounce4 #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic       any_pressed
);

  typedef enum logic [1:0] {
    REL        = 2'd0,
    PRESS_WAIT = 2'd1,
    PRS        = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0] s1_q, s2_q;
  logic [3:0] s1_d, s2_d;
  logic [3:0] level_d;
  logic       any_q;

  always_comb begin
    s1_d = btn_raw ^ {4{ACTIVE_LOW}};
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q  <= 4'b0000;
      s2_q  <= 4'b0000;
      any_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      // Built from the next-level vector so it moves on the same edge.
      any_q <= |level_d;
    end
  end

  assign any_pressed = any_q;

  for (genvar g = 0; g < 4; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, press_q, release_q;
    logic             lvl_d, press_d, release_d;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lvl_d     = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        REL: begin
          if (s2_q[g]) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q[g]) begin
            state_d = REL;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRS;
            cnt_d   = '0;
            lvl_d   = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        PRS: begin
          if (!s2_q[g]) begin
            state_d = REL_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        REL_WAIT: begin
          if (s2_q[g]) begin
            state_d   = PRS;
            cnt_d     = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = REL;
            cnt_d     = '0;
            lvl_d     = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d     = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = REL;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q   <= REL;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= lvl_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign level_d[g]     = lvl_d;
    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_button_debounce4.sv
// ---------------------------------------------------------------------------
// tb_button_debounce4 : scoreboard bench, active-high and active-low DUTs
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_button_debounce4;

  localparam int D = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw   = 4'b0000;
  logic [3:0] raw_n;

  logic [3:0] lvl_h, prs_h, rls_h;
  logic       any_h;
  logic [3:0] lvl_l, prs_l, rls_l;
  logic       any_l;

  assign raw_n = ~raw;

  always #5 clk = ~clk;

  button_debounce4 #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1'b0)) u_dut_ah (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw),
    .btn_level(lvl_h), .btn_press(prs_h), .btn_release(rls_h), .any_pressed(any_h)
  );

  button_debounce4 #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_n),
    .btn_level(lvl_l), .btn_press(prs_l), .btn_release(rls_l), .any_pressed(any_l)
  );

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rls;
    logic       any;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a level flips once the synchronized input has differed
  // from it for D consecutive edges.
  logic [3:0] m_s1  = 4'b0000;
  logic [3:0] m_s2  = 4'b0000;
  logic [3:0] m_lvl = 4'b0000;
  int         m_run [4];

  task automatic model_edge(input logic [3:0] r, input logic rn);
    exp_t e;
    e.prs = 4'b0000;
    e.rls = 4'b0000;
    if (!rn) begin
      m_s1  = 4'b0000;
      m_s2  = 4'b0000;
      m_lvl = 4'b0000;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_lvl[i]) m_run[i] = m_run[i] + 1;
        else                     m_run[i] = 0;
        if (m_run[i] == D) begin
          m_lvl[i] = ~m_lvl[i];
          if (m_lvl[i]) e.prs[i] = 1'b1;
          else          e.rls[i] = 1'b1;
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = r;
    end
    e.lvl = m_lvl;
    e.any = |m_lvl;
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic [3:0] r, input logic rn);
    raw   = r;
    rst_n = rn;
    @(posedge clk);
    model_edge(r, rn);
    #1;
  endtask

  task automatic compare(input string name, input exp_t e, input exp_t a);
    checks = checks + 1;
    if (a !== e) begin
      errors = errors + 1;
      $display("FAIL %s @%0t: got lvl=%b prs=%b rls=%b any=%b, expected lvl=%b prs=%b rls=%b any=%b",
               name, $time, a.lvl, a.prs, a.rls, a.any, e.lvl, e.prs, e.rls, e.any);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare("active_high", e, {lvl_h, prs_h, rls_h, any_h});
      compare("active_low",  e, {lvl_l, prs_l, rls_l, any_l});
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) m_run[i] = 0;

    repeat (3) tick(4'b0000, 1'b0);
    repeat (6) tick(4'b0000, 1'b1);
    // Single channel press, then release.
    repeat (12) tick(4'b0001, 1'b1);
    repeat (12) tick(4'b0000, 1'b1);
    // Bounce shorter than the debounce window.
    repeat (3) tick(4'b0010, 1'b1);
    repeat (8) tick(4'b0000, 1'b1);
    // Pulse exactly D cycles long is accepted.
    repeat (D) tick(4'b1000, 1'b1);
    repeat (12) tick(4'b0000, 1'b1);
    // Two channels together.
    repeat (20) tick(4'b1001, 1'b1);
    repeat (12) tick(4'b0000, 1'b1);
    // Reset mid-count.
    repeat (4) tick(4'b0100, 1'b1);
    tick(4'b0100, 1'b0);
    repeat (10) tick(4'b0100, 1'b1);
    repeat (12) tick(4'b0000, 1'b1);
    // Reset while a level is held.
    repeat (10) tick(4'b1111, 1'b1);
    tick(4'b1111, 1'b0);
    repeat (10) tick(4'b1111, 1'b1);

    // Randomized segments: random pattern held 1..7 cycles, rare resets.
    for (int s = 0; s < 1200; s++) begin
      logic [3:0] pat;
      int         len;
      pat = 4'($urandom);
      len = int'($urandom_range(1, 7));
      for (int k = 0; k < len; k++)
        tick(pat, ($urandom_range(0, 79) != 0));
    end
    repeat (12) tick(4'b0000, 1'b1);

    repeat (3) @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
